// File: rtl/usb_rx_bit_timer.sv
// ---------------------------------------------------------------------------
// usb_rx_bit_timer
//
// Receive-side bit timing for a USB full/low-speed PHY. A phase counter
// divides each bit time into CLKS_PER_BIT clocks and produces a sample strobe
// at SAMPLE_POINT. On each sample the line is NRZI-decoded and bit-stuffing is
// removed. Every surviving data bit is presented as a one-cycle shift_enable
// pulse with bit_out. Byte boundaries are flagged with byte_received.
//
// Build option:
//   USB_RX_RESYNC_EN  defined   -> each d_edge pulse realigns the phase counter
//                                  to 0. A sample due in the same cycle is
//                                  still taken.
//                     undefined -> d_edge is ignored and the phase counter
//                                  free-runs from 0 at the start of a packet.
//
// Ports:
//   clk            in   system clock, rising edge
//   n_rst          in   asynchronous active-low reset
//   rcving         in   high for the whole packet, low while idle
//   d_edge         in   one-cycle pulse on any synchronized D+ transition
//   d_plus_sync    in   synchronized D+ level
//   shift_enable   out  one-cycle pulse per decoded, unstuffed data bit
//   bit_out        out  decoded data bit, valid with shift_enable
//   byte_received  out  one-cycle pulse with the 8th shift_enable of a byte
//   stuff_error    out  sticky bit-stuffing violation flag for this packet
// ---------------------------------------------------------------------------
module usb_rx_bit_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic rcving,
    input  logic d_edge,
    input  logic d_plus_sync,
    output logic shift_enable,
    output logic bit_out,
    output logic byte_received,
    output logic stuff_error
);

    localparam int PHASE_W = $clog2(CLKS_PER_BIT);
    localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(CLKS_PER_BIT - 1);
    localparam logic [PHASE_W-1:0] PHASE_SAMPLE = PHASE_W'(SAMPLE_POINT);

    logic [PHASE_W-1:0] phase;
    logic [2:0]         ones;
    logic [2:0]         bit_cnt;
    logic               prev_level;

    logic               sample;
    logic               decoded;
    logic               is_stuff;
    logic               resync;
    logic [PHASE_W-1:0] phase_next;

    // Phase advance with wrap at the end of a bit time.
    function automatic logic [PHASE_W-1:0] phase_step(input logic [PHASE_W-1:0] cur);
        return (cur == PHASE_LAST) ? '0 : cur + PHASE_W'(1);
    endfunction

`ifdef USB_RX_RESYNC_EN
    assign resync = d_edge;
`else
    logic unused_d_edge;
    assign unused_d_edge = d_edge;
    assign resync        = 1'b0;
`endif

    assign sample     = rcving && (phase == PHASE_SAMPLE);
    // NRZI: no transition since the previous sample means a 1.
    assign decoded    = (d_plus_sync == prev_level);
    // After six 1s the transmitter inserts a 0. That slot is never data.
    assign is_stuff   = (ones == 3'd6);
    // The sample uses the current phase, so an edge landing on the sample
    // point still gets sampled before the counter is realigned.
    assign phase_next = resync ? '0 : phase_step(phase);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase         <= '0;
            ones          <= 3'd0;
            bit_cnt       <= 3'd0;
            prev_level    <= 1'b1;
            shift_enable  <= 1'b0;
            bit_out       <= 1'b0;
            byte_received <= 1'b0;
            stuff_error   <= 1'b0;
        end else if (!rcving) begin
            // Idle: drop any partial byte and rearm for the next packet.
            // The line idles at J, so the next NRZI reference is 1.
            phase         <= '0;
            ones          <= 3'd0;
            bit_cnt       <= 3'd0;
            prev_level    <= 1'b1;
            shift_enable  <= 1'b0;
            byte_received <= 1'b0;
            stuff_error   <= 1'b0;
        end else begin
            phase         <= phase_next;
            shift_enable  <= 1'b0;
            byte_received <= 1'b0;
            if (sample) begin
                prev_level <= d_plus_sync;
                if (is_stuff) begin
                    // A 1 where a stuffed 0 was required is a violation.
                    // ones stays at 6, so later samples are also rejected.
                    if (decoded) begin
                        stuff_error <= 1'b1;
                    end else begin
                        ones <= 3'd0;
                    end
                end else begin
                    ones          <= decoded ? ones + 3'd1 : 3'd0;
                    shift_enable  <= 1'b1;
                    bit_out       <= decoded;
                    bit_cnt       <= bit_cnt + 3'd1;
                    byte_received <= (bit_cnt == 3'd7);
                end
            end
        end
    end

endmodule

// File: doc/usb_rx_bit_timer.md
USB_RX_BIT_TIMER -- requirements
Module: usb_rx_bit_timer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, clk cycles per USB bit time (legal 4..15).
REQ-002 SHALL have parameter SAMPLE_POINT, default 3, phase value at which the line is sampled (legal 1..CLKS_PER_BIT-2).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rcving  input  1  high for the duration of a packet; low = idle.
REQ-006 SHALL have port d_edge  input  1  one-cycle pulse on any synchronized D+ transition.
REQ-007 SHALL have port d_plus_sync  input  1  synchronized D+ level.
REQ-008 SHALL have port shift_enable  output  1  one-cycle pulse per decoded, unstuffed data bit.
REQ-009 SHALL have port bit_out  output  1  decoded data bit, valid while shift_enable is high.
REQ-010 SHALL have port byte_received  output  1  one-cycle pulse on the 8th shift_enable of each byte.
REQ-011 SHALL have port stuff_error  output  1  sticky flag, bit-stuffing violation seen in current packet.

Function
REQ-012 SHALL keep a phase counter, width $clog2(CLKS_PER_BIT); while rcving=1: phase <= (phase==CLKS_PER_BIT-1) ? 0 : phase+1.
REQ-013 SHALL, while rcving=1 and d_edge=1, load phase <= 0 (resync), overriding REQ-012.
REQ-014 SHALL generate an internal sample strobe in any cycle with rcving=1 and phase==SAMPLE_POINT.
REQ-015 SHALL NRZI-decode on sample: decoded bit = 1 if d_plus_sync equals prev_level, else 0; prev_level <= d_plus_sync.
REQ-016 SHALL keep a ones counter 0..6: on sample, decoded 1 -> increment, decoded 0 -> clear.
REQ-017 SHALL treat a sample taken with ones==6 as a stuff bit: decoded 0 -> no shift_enable, ones <= 0; decoded 1 -> stuff_error <= 1, no shift_enable, ones held at 6.
REQ-018 SHALL, for every non-stuff sample, assert shift_enable and bit_out (decoded value) in the cycle following the sample strobe, for exactly one cycle.
REQ-019 SHALL keep a 3-bit bit counter incremented per shift_enable, wrapping 7 -> 0.
REQ-020 SHALL assert byte_received in the same cycle as the shift_enable that takes the bit counter from 7 to 0.
REQ-021 SHALL hold stuff_error at 1 until rcving=0.
REQ-022 SHALL, in any cycle with rcving=0, synchronously set phase=0, ones=0, bit counter=0, prev_level=1, and drive shift_enable=0, byte_received=0, stuff_error=0 next cycle.
REQ-023 SHALL, on rcving falling mid-bit or mid-byte, discard the partial byte without asserting byte_received.
REQ-024 SHALL give d_edge coinciding with phase==SAMPLE_POINT priority to the sample (sample taken, then phase <= 0).
REQ-025 SHALL drive all outputs directly from flops.

Reset
REQ-026 SHALL, on n_rst=0, asynchronously set shift_enable=0, bit_out=0, byte_received=0, stuff_error=0, phase=0, ones=0, bit counter=0, prev_level=1.
REQ-027 SHALL, after n_rst deassertion, start counting only once rcving=1.

Configuration
REQ-028 SHALL honour macro USB_RX_RESYNC_EN: defined -> REQ-013 and REQ-024 active; undefined -> d_edge ignored, phase free-runs from 0 on the first rcving=1 cycle.

Verification
REQ-029 SHALL cover: reset with n_rst=0 mid-packet -> all outputs 0 within same cycle, prev_level=1.
REQ-030 SHALL cover: SYNC pattern KJKJKJKK at 8 clk/bit -> 8 shift_enable pulses spaced 8 cycles, bits 00000001, byte_received with the 8th.
REQ-031 SHALL cover: six 1s followed by a stuffed 0 then data 0 -> 6 pulses, stuffed bit suppressed, next pulse 16 cycles after the 6th with bit_out=0.
REQ-032 SHALL cover: seven consecutive 1s -> stuff_error=1 at 7th sample +1 cycle, held until rcving=0, then 0.
REQ-033 SHALL cover (USB_RX_RESYNC_EN defined): edges arriving every 9 cycles -> sampling tracks edges, no bit slip over 32 bits; undefined -> drift observed per model.
REQ-034 SHALL cover: rcving dropped after 5 bits -> no byte_received, next packet's first byte_received after exactly 8 bits.
